// File: rtl/hex_display_mux.sv
// Time-multiplexed hex driver for an N-digit common-anode seven-segment display.
// Inputs are snapshotted once per frame so a displayed value never tears mid-scan.
module hex_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 500000
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_lz_en,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
  logic [NUM_DIGITS-1:0]   dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
  logic                    lz_en_reg, lz_en_next;
  logic                    terminal, frame;

  logic [6:0]              seg_next;
  logic                    dp_out_next;
  logic [NUM_DIGITS-1:0]   an_next;

  logic [3:0]              nib [NUM_DIGITS];
  logic [6:0]              slot_seg [NUM_DIGITS];
  logic                    slot_dp [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   suppress;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    terminal    = (cnt_reg == CNT_MAX);
    frame       = terminal && (idx_reg == IDX_MAX);
    cnt_next    = terminal ? '0 : cnt_reg + 1'b1;
    idx_next    = idx_reg;
    if (terminal) begin
      idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
    end
    digits_next = frame ? i_digits : digits_reg;
    dp_next     = frame ? i_dp     : dp_reg;
    blank_next  = frame ? i_blank  : blank_reg;
    lz_en_next  = frame ? i_lz_en  : lz_en_reg;
  end

  // Scan from the most significant digit down; a zero digit stays dark only
  // while every digit above it was also zero. Digit 0 is always shown.
  always_comb begin
    logic run;
    suppress = '0;
    run      = lz_en_next;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run         = run && (nib[k] == 4'h0);
      suppress[k] = run && (k != 0);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      assign nib[gi]      = digits_next[4*gi +: 4];
      assign slot_seg[gi] = (blank_next[gi] || suppress[gi]) ? 7'h7F : decode(nib[gi]);
      assign slot_dp[gi]  = blank_next[gi] | ~dp_next[gi];
    end
  endgenerate

  always_comb begin
    an_next     = '0;
    seg_next    = 7'h7F;
    dp_out_next = 1'b1;
    if (i_enable) begin
      an_next     = NUM_DIGITS'(1) << idx_next;
      seg_next    = slot_seg[idx_next];
      dp_out_next = slot_dp[idx_next];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_reg    <= CNT_MAX;
      idx_reg    <= IDX_MAX;
      digits_reg <= '0;
      dp_reg     <= '0;
      blank_reg  <= '0;
      lz_en_reg  <= 1'b0;
      o_seg      <= 7'h7F;
      o_dp       <= 1'b1;
      o_an       <= '0;
      o_frame    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      digits_reg <= digits_next;
      dp_reg     <= dp_next;
      blank_reg  <= blank_next;
      lz_en_reg  <= lz_en_next;
      o_seg      <= seg_next;
      o_dp       <= dp_out_next;
      o_an       <= an_next;
      o_frame    <= frame;
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Scoreboard bench for hex_display_mux with 4 digits and a 4-cycle slot:
// one expected output word is queued per clock edge and compared after it.
module tb_hex_display_mux;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [15:0]   digits;
  logic [3:0]    dp;
  logic [3:0]    blank;
  logic          lz;
  logic [6:0]    o_seg;
  logic          o_dp;
  logic [3:0]    o_an;
  logic          o_frame;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t        sb [$];
  exp_t        e;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc;            // edges since the last frame boundary, mod 16
  logic [15:0] snap_d;
  logic [3:0]  snap_dp, snap_blk;
  logic        snap_lz;
  logic [6:0]  seg_tab [16];

  hex_display_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_enable (en),
    .i_digits (digits),
    .i_dp     (dp),
    .i_blank  (blank),
    .i_lz_en  (lz),
    .o_seg    (o_seg),
    .o_dp     (o_dp),
    .o_an     (o_an),
    .o_frame  (o_frame)
  );

  always #5 clk = ~clk;

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  end

  // Advance the model by one edge and return what the display must show after it.
  function automatic exp_t step_model();
    exp_t r;
    int   slot;
    logic sup;
    cyc = (cyc + 1) % 16;
    if (cyc == 0) begin
      snap_d   = digits;
      snap_dp  = dp;
      snap_blk = blank;
      snap_lz  = lz;
    end
    slot    = cyc / DIV;
    r.frame = (cyc == 0);
    r.an    = 4'b0000;
    r.seg   = 7'h7F;
    r.dp    = 1'b1;
    if (en) begin
      r.an = 4'b0001 << slot;
      sup  = snap_lz && (slot >= 1);
      for (int j = slot; j < ND; j++) begin
        if (snap_d[4*j +: 4] != 4'h0) sup = 1'b0;
      end
      if (snap_blk[slot]) begin
        r.seg = 7'h7F;
        r.dp  = 1'b1;
      end else begin
        r.seg = sup ? 7'h7F : seg_tab[snap_d[4*slot +: 4]];
        r.dp  = ~snap_dp[slot];
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    digits = 16'h12AF;
    dp     = 4'b0000;
    blank  = 4'b0000;
    lz     = 1'b0;
    snap_d = '0; snap_dp = '0; snap_blk = '0; snap_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({o_an, o_seg, o_dp, o_frame} !== {4'b0000, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: an=%b seg=%b dp=%b frame=%b, required an=0000 seg=1111111 dp=1 frame=0",
               o_an, o_seg, o_dp, o_frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 15;
    for (int c = 0; c < 33; c++) begin
      sb.push_back(step_model());
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if ({o_an, o_seg, o_dp, o_frame} !== e) begin
        tests_failed++;
        $display("FAIL first_frame cyc=%0d: an=%b seg=%b dp=%b frame=%b, required an=%b seg=%b dp=%b frame=%b",
                 cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
      end
    end
  endtask

  task automatic test_snapshot();
    for (int c = 0; c < 32; c++) begin
      if (c == 5) digits = 16'h0000;
      sb.push_back(step_model());
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if ({o_an, o_seg, o_dp, o_frame} !== e) begin
        tests_failed++;
        $display("FAIL snapshot cyc=%0d: an=%b seg=%b dp=%b frame=%b, required an=%b seg=%b dp=%b frame=%b",
                 cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
      end
    end
  endtask

  task automatic test_leading_zero();
    for (int c = 0; c < 64; c++) begin
      if (c == 0) begin
        digits = 16'h0050;
        lz     = 1'b1;
      end
      if (c == 32) digits = 16'h0000;
      sb.push_back(step_model());
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if ({o_an, o_seg, o_dp, o_frame} !== e) begin
        tests_failed++;
        $display("FAIL leading_zero cyc=%0d: an=%b seg=%b dp=%b frame=%b, required an=%b seg=%b dp=%b frame=%b",
                 cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
      end
    end
  endtask

  task automatic test_blank_dp();
    for (int c = 0; c < 32; c++) begin
      if (c == 0) begin
        digits = 16'h12AF;
        lz     = 1'b0;
        dp     = 4'b0101;
        blank  = 4'b0100;
      end
      sb.push_back(step_model());
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if ({o_an, o_seg, o_dp, o_frame} !== e) begin
        tests_failed++;
        $display("FAIL blank_dp cyc=%0d: an=%b seg=%b dp=%b frame=%b, required an=%b seg=%b dp=%b frame=%b",
                 cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
      end
    end
  endtask

  task automatic test_enable();
    for (int c = 0; c < 32; c++) begin
      en = !(c >= 6 && c < 12);
      sb.push_back(step_model());
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if ({o_an, o_seg, o_dp, o_frame} !== e) begin
        tests_failed++;
        $display("FAIL enable cyc=%0d: an=%b seg=%b dp=%b frame=%b, required an=%b seg=%b dp=%b frame=%b",
                 cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 9; c++) begin
      sb.push_back(step_model());
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if ({o_an, o_seg, o_dp, o_frame} !== e) begin
        tests_failed++;
        $display("FAIL pre_reset cyc=%0d: an=%b seg=%b dp=%b frame=%b, required an=%b seg=%b dp=%b frame=%b",
                 cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_an, o_seg, o_dp, o_frame} !== {4'b0000, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: an=%b seg=%b dp=%b frame=%b, required an=0000 seg=1111111 dp=1 frame=0",
               o_an, o_seg, o_dp, o_frame);
    end
    snap_d = '0; snap_dp = '0; snap_blk = '0; snap_lz = 1'b0;
    digits = 16'h3C07;
    dp     = 4'b1000;
    blank  = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 15;
    for (int c = 0; c < 17; c++) begin
      sb.push_back(step_model());
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if ({o_an, o_seg, o_dp, o_frame} !== e) begin
        tests_failed++;
        $display("FAIL post_reset cyc=%0d: an=%b seg=%b dp=%b frame=%b, required an=%b seg=%b dp=%b frame=%b",
                 cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
      end
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_leading_zero();
    test_blank_dp();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
